// File: rtl/io_input_conditioner.sv
// Board switch/key conditioner: two-flop synchronizer plus per-channel debounce,
// producing clean active-high levels and one-cycle key press/release strobes.
module io_input_conditioner #(
  parameter int unsigned SW_WIDTH        = 10,
  parameter int unsigned KEY_WIDTH       = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic                          clock_i,
  input  logic                          reset_ni,
  input  logic [SW_WIDTH-1:0]           sw_i,
  input  logic [KEY_WIDTH-1:0]          key_i,
  output logic [SW_WIDTH+KEY_WIDTH-1:0] io_input_bus,
  output logic [KEY_WIDTH-1:0]          key_press_o,
  output logic [KEY_WIDTH-1:0]          key_release_o
);

  localparam int N = int'(SW_WIDTH + KEY_WIDTH);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [N-1:0]            raw;
  logic [N-1:0]            s1_q, s2_q;
  logic [N-1:0]            stable_q, stable_d;
  logic [N-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_WIDTH-1:0]    press_q, press_d;
  logic [KEY_WIDTH-1:0]    release_q, release_d;
  logic [KEY_WIDTH-1:0]    key_old, key_new;

  // Keys normalised so that pressed reads as 1 on every channel.
  assign raw = {key_i ^ {KEY_WIDTH{KEY_ACTIVE_LOW}}, sw_i};

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    for (int i = 0; i < N; i++) begin
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntOne;
        end
      end
    end
  end

  assign key_old   = stable_q[N-1:SW_WIDTH];
  assign key_new   = stable_d[N-1:SW_WIDTH];
  assign press_d   = key_new & ~key_old;
  assign release_d = ~key_new & key_old;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      s1_q      <= '0;
      s2_q      <= '0;
      stable_q  <= '0;
      cnt_q     <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      s1_q      <= raw;
      s2_q      <= s1_q;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign io_input_bus  = stable_q;
  assign key_press_o   = press_q;
  assign key_release_o = release_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Bench for io_input_conditioner: directed scenarios plus random levels, with a
// history-window reference model feeding a per-cycle scoreboard.
module tb_io_input_conditioner;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  sw;
  logic [3:0]  key;
  logic [13:0] bus;
  logic [3:0]  press, rel;

  int n_checks = 0;
  int n_fail   = 0;

  io_input_conditioner #(
    .SW_WIDTH       (10),
    .KEY_WIDTH      (4),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3),
    .KEY_ACTIVE_LOW (1'b1)
  ) dut (
    .clock_i      (clk),
    .reset_ni     (rst_n),
    .sw_i         (sw),
    .key_i        (key),
    .io_input_bus (bus),
    .key_press_o  (press),
    .key_release_o(rel)
  );

  always #5 clk = ~clk;

  // Reference model: s2 seen at edge n is the raw sample of edge n-2; a channel
  // flips when its last D s2 samples all agree and differ from the accepted level.
  logic [13:0] m_stable;
  logic [13:0] rawq[$];
  logic [13:0] s2h[$];
  logic [21:0] expq[$];

  task automatic model_reset();
    m_stable = '0;
    rawq.delete();
    rawq.push_back(14'h0);
    rawq.push_back(14'h0);
    s2h.delete();
  endtask

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    if (!rst_n) begin
      model_reset();
      expq.push_back(22'h0);
    end else begin
      logic [13:0] prev, s2;
      logic        agree;
      prev = m_stable;
      rawq.push_back({key ^ 4'hF, sw});
      s2 = rawq[rawq.size() - 3];
      if (rawq.size() > 3) void'(rawq.pop_front());
      s2h.push_back(s2);
      if (s2h.size() > D) void'(s2h.pop_front());
      if (s2h.size() == D) begin
        for (int ch = 0; ch < 14; ch++) begin
          agree = 1'b1;
          for (int j = 1; j < D; j++) if (s2h[j][ch] != s2h[0][ch]) agree = 1'b0;
          if (agree) m_stable[ch] = s2h[0][ch];
        end
      end
      expq.push_back({~m_stable[13:10] & prev[13:10], m_stable[13:10] & ~prev[13:10], m_stable});
    end
  end

  // Monitor: the DUT presents a result every edge.
  always @(posedge clk) begin
    logic [21:0] e;
    #1;
    n_checks++;
    if (expq.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: no expected entry at time %0t", $time);
    end else begin
      e = expq.pop_front();
      if ({rel, press, bus} !== e) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t: got bus=%h press=%h rel=%h, expected bus=%h press=%h rel=%h",
                 $time, bus, press, rel, e[13:0], e[17:14], e[21:18]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] m_sw;
    logic [3:0] m_key;
    // Reset with all channels asserted; outputs must be zero before any edge.
    rst_n = 1'b0;
    sw    = 10'h3FF;
    key   = 4'h0;
    #1;
    chk("reset_bus_noclk", 32'(bus), 32'h0);
    chk("reset_strobe_noclk", 32'({press, rel}), 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    chk("reset_bus_edge5", 32'(bus), 32'h0);
    tick(1);
    chk("reset_bus_edge6", 32'(bus), 32'h3FFF);
    chk("reset_press_edge6", 32'(press), 32'hF);
    tick(1);
    chk("reset_press_edge7", 32'(press), 32'h0);

    sw  = 10'h0;
    key = 4'hF;
    tick(8);
    chk("idle_bus", 32'(bus), 32'h0);

    // Clean switch.
    sw[3] = 1'b1;
    tick(5);
    chk("sw3_edge5", 32'(bus), 32'h0);
    tick(1);
    chk("sw3_edge6", 32'(bus), 32'h0008);
    chk("sw3_no_strobe", 32'({press, rel}), 32'h0);

    // Bounce rejection: key0 pressed for 3 cycles only.
    key[0] = 1'b0;
    tick(3);
    key[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("bounce_bit10", 32'(bus[10]), 32'h0);
      chk("bounce_press", 32'(press), 32'h0);
    end

    // Bounce then settle on key1.
    key[1] = 1'b0; tick(1);
    key[1] = 1'b1; tick(1);
    key[1] = 1'b0; tick(1);
    key[1] = 1'b1; tick(1);
    key[1] = 1'b0;
    tick(5);
    chk("settle_bit11_edge5", 32'(bus[11]), 32'h0);
    tick(1);
    chk("settle_bit11_edge6", 32'(bus[11]), 32'h1);
    chk("settle_press", 32'(press), 32'h2);
    tick(1);
    chk("settle_press_gone", 32'(press), 32'h0);
    key[1] = 1'b1;
    tick(5);
    chk("release_bit11_edge5", 32'(bus[11]), 32'h1);
    tick(1);
    chk("release_bit11_edge6", 32'(bus[11]), 32'h0);
    chk("release_strobe", 32'(rel), 32'h2);

    // Simultaneous and independent channels.
    sw[0]  = 1'b1;
    key[3] = 1'b0;
    tick(2);
    sw[9] = 1'b1;
    tick(3);
    chk("simul_edge5", 32'(bus), 32'h0008);
    tick(1);
    chk("simul_edge6", 32'(bus), 32'h2009);
    chk("simul_press", 32'(press), 32'h8);
    tick(1);
    chk("simul_edge7", 32'(bus), 32'h2009);
    tick(1);
    chk("simul_edge8", 32'(bus), 32'h2209);

    // Reset mid-count on sw5.
    sw  = 10'h020;
    key = 4'hF;
    tick(8);
    sw[5] = 1'b0;
    tick(8);
    sw[5] = 1'b1;
    tick(4);
    rst_n = 1'b0;
    #1;
    chk("midcount_reset_bus", 32'(bus), 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    chk("midcount_bit5_edge5", 32'(bus[5]), 32'h0);
    tick(1);
    chk("midcount_bit5_edge6", 32'(bus[5]), 32'h1);

    // Random phase: sparse bit flips held for random lengths, occasional reset.
    m_sw  = sw;
    m_key = key;
    for (int r = 0; r < 400; r++) begin
      m_sw  = m_sw ^ (10'($urandom) & 10'($urandom) & 10'($urandom));
      m_key = m_key ^ (4'($urandom) & 4'($urandom));
      sw    = m_sw;
      key   = m_key;
      tick($urandom_range(1, 7));
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        #1;
        chk("rand_reset_bus", 32'({rel, press, bus}), 32'h0);
        tick($urandom_range(1, 3));
        rst_n = 1'b1;
      end
    end
    tick(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_input_conditioner.md
# io_input_conditioner

Conditions the raw board switches and push-buttons before they reach the CPU's memory-mapped input port. Each of the 14 raw inputs passes through a two-flop synchronizer and a per-channel debounce counter. The block drives the CPU's `io_input_bus` with a clean, active-high level per channel, `|13 KEY 10|9 SW 0|`. It also emits one-cycle press/release strobes per key for optional use by interrupt or event logic.

## Interface

Parameters:
- `SW_WIDTH`, 10, number of slide switches (bus bits [9:0]).
- `KEY_WIDTH`, 4, number of push-buttons (bus bits [13:10]).
- `DEBOUNCE_CYCLES`, 500000, consecutive stable cycles required to accept a new level (10 ms at 50 MHz). Must be ≥ 1.
- `CNT_W`, 19, debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `KEY_ACTIVE_LOW`, 1, if 1, raw keys are inverted at the input so that pressed = 1.

Ports:
- `clock_i`  in  1  system clock, same clock as the CPU.
- `reset_ni`  in  1  asynchronous, active-low reset.
- `sw_i`  in  SW_WIDTH  raw switch pins, asynchronous to `clock_i`.
- `key_i`  in  KEY_WIDTH  raw key pins, asynchronous to `clock_i`.
- `io_input_bus`  out  SW_WIDTH+KEY_WIDTH  debounced levels: [9:0] switches, [13:10] keys (1 = pressed).
- `key_press_o`  out  KEY_WIDTH  one-cycle strobe when a debounced key goes 0→1.
- `key_release_o`  out  KEY_WIDTH  one-cycle strobe when a debounced key goes 1→0.

## Operation

- Channel vector: raw[i] = {key_i ^ {KEY_WIDTH{KEY_ACTIVE_LOW}}, sw_i}, 14 independent channels.
- Synchronizer per channel: s1 <= raw, then s2 <= s1. This path is only for metastability; no logic sits between s1 and s2.
- Debounce per channel, with registers `stable` (1 bit) and `cnt` (CNT_W bits):
  - s2 == stable: cnt <= 0.
  - s2 != stable and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= s2 and cnt <= 0.
- Any bounce that returns s2 to `stable` before acceptance clears `cnt`. Acceptance therefore needs DEBOUNCE_CYCLES consecutive disagreeing samples.
- `io_input_bus` = stable vector, driven directly from registers with no combinational path from the pins.
- Strobes are registered at the same edge that updates `stable`:
  - `key_press_o[k]` = 1 for exactly one cycle when the key's stable value flips 0→1.
  - `key_release_o[k]` = 1 for exactly one cycle when it flips 1→0.
  - Otherwise both strobes are 0.
- Switch channels have no strobes.
- `cnt` never exceeds DEBOUNCE_CYCLES-1, so it cannot wrap.

## Timing

- Reset (async assert, sync-safe deassert handled upstream):
  - s1, s2, stable, cnt = 0.
  - `io_input_bus` = 14'h0.
  - `key_press_o` = `key_release_o` = 0.
  - Outputs go to 0 immediately on assert, with no clock required.
- Latency: a raw level held steady is reflected on `io_input_bus` at the (DEBOUNCE_CYCLES+2)th rising edge after the change. Edge 1 loads s1, edge 2 loads s2, and the next DEBOUNCE_CYCLES edges count.
- The strobe is coincident with the `io_input_bus` change and lasts 1 cycle.
- A raw pulse shorter than DEBOUNCE_CYCLES cycles at s2 produces no output change and no strobe.
- Channels are fully independent; simultaneous changes on several channels are each accepted on their own schedule.
- Reset mid-count discards the partial count.
  - If inputs are held non-zero through reset, they reappear DEBOUNCE_CYCLES+2 edges after reset release.
  - A held key then also produces a `key_press_o` strobe, since stable goes 0→1.
- DEBOUNCE_CYCLES = 1: acceptance happens on the first disagreeing sample, giving a latency of 3 edges.

## Test plan

Run all tests with DEBOUNCE_CYCLES=4 and CNT_W=3.

- Reset: hold reset_ni=0 with sw_i=10'h3FF and key_i=4'h0. Required: `io_input_bus`=0 and strobes=0 without any clock edge. After release, `io_input_bus`=14'h3FFF at edge 6, and `key_press_o`=4'hF for that single cycle.
- Clean switch: from 0, set sw_i[3]=1. Required: `io_input_bus`=14'h0008 exactly at edge 6, not at edge 5, and no strobes.
- Bounce rejection: key_i[0] (active-low) pulses 0 for 3 cycles, then returns to 1. Required: `io_input_bus`[10] stays 0 and no strobe fires.
- Bounce then settle: key_i[1] toggles 0,1,0,1, then holds 0. Required: bit 11 rises 6 edges after the final 1→0 transition, and `key_press_o`=4'b0010 for 1 cycle. On release, bit 11 falls 6 edges later with `key_release_o`=4'b0010.
- Simultaneous and independent: change sw_i[0] and key_i[3] on the same edge, and sw_i[9] two cycles later. Required: bits 0 and 13 update at edge 6, and bit 9 at edge 8.
- Reset mid-count: assert reset_ni at count 2 while sw_i[5]=1, release it, and keep sw_i[5]=1. Required: bit 5 reads 0 until edge 6 after release, then reads 1.
